// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, control bundle
// and the canned control patterns the FSM selects between.
package cpu_types_pkg;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    LU_STALL  = 3'd1,
    DMEM_WAIT = 3'd2,
    FLUSH     = 3'd3,
    HALTED    = 3'd4
  } hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_w;
    logic if_rst;
    logic idex_w;
    logic idex_rst;
    logic exmem_w;
    logic memwb_w;
    logic memwb_rst;
    logic halted;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_DEFAULT = '{pc_en: 1'b1, if_w: 1'b1, if_rst: 1'b0,
                                        idex_w: 1'b1, idex_rst: 1'b0, exmem_w: 1'b1,
                                        memwb_w: 1'b1, memwb_rst: 1'b0, halted: 1'b0};

  localparam hz_ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_w: 1'b0, if_rst: 1'b1,
                                      idex_w: 1'b0, idex_rst: 1'b1, exmem_w: 1'b0,
                                      memwb_w: 1'b0, memwb_rst: 1'b1, halted: 1'b0};

  localparam hz_ctrl_t CTRL_HALT = '{pc_en: 1'b0, if_w: 1'b0, if_rst: 1'b0,
                                     idex_w: 1'b0, idex_rst: 1'b0, exmem_w: 1'b0,
                                     memwb_w: 1'b0, memwb_rst: 1'b0, halted: 1'b1};

  // Front end and EX/MEM frozen; MEM/WB gets a bubble while the data access is outstanding.
  localparam hz_ctrl_t CTRL_DWAIT = '{pc_en: 1'b0, if_w: 1'b0, if_rst: 1'b0,
                                      idex_w: 1'b0, idex_rst: 1'b0, exmem_w: 1'b0,
                                      memwb_w: 1'b1, memwb_rst: 1'b1, halted: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the load in ID/EX and the sources in IF/ID.
module hazard_detect
  import cpu_types_pkg::*;
#(
  parameter int RSEL_W = 5
) (
  input  logic              ex_memread,
  input  logic [RSEL_W-1:0] ex_rd,
  input  logic [RSEL_W-1:0] id_rsel1,
  input  logic [RSEL_W-1:0] id_rsel2,
  output logic              lu_hazard
);

  // Register 0 is hard-wired, so a load targeting it never blocks a consumer.
  always_comb begin
    lu_hazard = ex_memread
             && (ex_rd != RSEL_W'(ZERO_REG))
             && ((ex_rd == id_rsel1) || (ex_rd == id_rsel2));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: stalls, flushes and halt for the five-stage core.
// Define HAZARD_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int RSEL_W       = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dreq,
  input  logic              ex_memread,
  input  logic [RSEL_W-1:0] ex_rd,
  input  logic [RSEL_W-1:0] id_rsel1,
  input  logic [RSEL_W-1:0] id_rsel2,
  input  logic              br_taken,
  input  logic              halt_req,
  output logic              pc_en,
  output logic              ifW,
  output logic              ifRST,
  output logic              idex_W,
  output logic              idex_RST,
  output logic              exmem_W,
  output logic              memwb_W,
  output logic              memwb_RST,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              halted
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  hz_state_t        state;
  hz_state_t        next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             resume;
  logic             resume_next;
  logic             lu_hazard;
  hz_ctrl_t         ctrl;

  hazard_detect #(.RSEL_W(RSEL_W)) u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rsel1   (id_rsel1),
    .id_rsel2   (id_rsel2),
    .lu_hazard  (lu_hazard)
  );

  // State, remaining-flush counter and the "return to FLUSH after the data wait" flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      cnt    <= CNT_ZERO;
      resume <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      resume <= resume_next;
    end
  end

  // Next-state and same-cycle control decode.
  always_comb begin
    ctrl        = CTRL_DEFAULT;
    next_state  = state;
    cnt_next    = cnt;
    resume_next = resume;
    if (RST) begin
      ctrl        = CTRL_RESET;
      next_state  = RUN;
      cnt_next    = CNT_ZERO;
      resume_next = 1'b0;
    end else begin
      case (state)
        HALTED: begin
          ctrl       = CTRL_HALT;
          next_state = HALTED;
        end
        DMEM_WAIT: begin
          if (halt_req) begin
            ctrl       = CTRL_HALT;
            next_state = HALTED;
          end else if (dhit) begin
            next_state  = resume ? FLUSH : RUN;
            resume_next = 1'b0;
          end else begin
            ctrl       = CTRL_DWAIT;
            next_state = DMEM_WAIT;
          end
        end
        RUN, LU_STALL, FLUSH: begin
          if (halt_req) begin
            ctrl       = CTRL_HALT;
            next_state = HALTED;
          end else if (mem_dreq && !dhit) begin
            // The flush counter is left untouched so it resumes after the wait.
            ctrl        = CTRL_DWAIT;
            next_state  = DMEM_WAIT;
            resume_next = (state == FLUSH);
          end else if (br_taken) begin
            ctrl.if_w     = 1'b0;
            ctrl.if_rst   = 1'b1;
            ctrl.idex_rst = 1'b1;
            cnt_next      = RELOAD;
            next_state    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (state == FLUSH) begin
            ctrl.pc_en    = ihit;
            ctrl.if_w     = 1'b0;
            ctrl.if_rst   = 1'b1;
            ctrl.idex_rst = 1'b1;
            cnt_next      = cnt - CNT_ONE;
            next_state    = (cnt <= CNT_ONE) ? RUN : FLUSH;
          end else if (lu_hazard && (state != LU_STALL)) begin
            ctrl.pc_en    = 1'b0;
            ctrl.if_w     = 1'b0;
            ctrl.idex_rst = 1'b1;
            next_state    = LU_STALL;
          end else if (!ihit) begin
            ctrl.pc_en  = 1'b0;
            ctrl.if_w   = 1'b0;
            ctrl.if_rst = 1'b1;
            next_state  = RUN;
          end else begin
            next_state = RUN;
          end
        end
        default: begin
          ctrl        = CTRL_RESET;
          next_state  = RUN;
          cnt_next    = CNT_ZERO;
          resume_next = 1'b0;
        end
      endcase
    end
  end

  assign pc_en     = ctrl.pc_en;
  assign ifW       = ctrl.if_w;
  assign ifRST     = ctrl.if_rst;
  assign idex_W    = ctrl.idex_w;
  assign idex_RST  = ctrl.idex_rst;
  assign exmem_W   = ctrl.exmem_w;
  assign memwb_W   = ctrl.memwb_w;
  assign memwb_RST = ctrl.memwb_rst;
  assign halted    = ctrl.halted;

`ifdef HAZARD_PERF_EN
  // Free-running wrap-around counters, frozen while the core is halted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (!ctrl.halted) begin
      if (!ctrl.pc_en) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (ctrl.if_rst) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives the IF/ID write enable (ifW) and flush (ifRST), the PC enable, and the downstream register write/flush strobes.
- Resolves four conditions every cycle: data-memory wait, branch/jump redirect, load-use hazard and instruction-fetch miss.
- Holds a small FSM so that multi-cycle flushes and halt are sequenced, not just decoded.

Parameters:
RSEL_W, 5, register-select width
FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed after a redirect (>=1)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access completed this cycle
mem_dreq  in  1  EX/MEM holds a load or store
ex_memread  in  1  ID/EX holds a load
ex_rd  in  RSEL_W  destination register of the load in ID/EX
id_rsel1  in  RSEL_W  source register 1 of the instruction in IF/ID
id_rsel2  in  RSEL_W  source register 2 of the instruction in IF/ID
br_taken  in  1  resolved taken branch/jump (redirect PC)
halt_req  in  1  halt instruction reached MEM/WB
pc_en  out  1  PC update enable
ifW  out  1  IF/ID write enable
ifRST  out  1  IF/ID flush (bubble)
idex_W  out  1  ID/EX write enable
idex_RST  out  1  ID/EX flush
exmem_W  out  1  EX/MEM write enable
memwb_W  out  1  MEM/WB write enable
memwb_RST  out  1  MEM/WB flush
halted  out  1  core halted

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high (RST), sampled on the rising edge.
- Output timing: state is registered; outputs are combinational from the state and current inputs (same-cycle stall).
- RST high, current cycle: pc_en=0, all *_W=0, ifRST=idex_RST=memwb_RST=1, halted=0. Next state RUN; flush counter=0.
- RST overrides everything, including HALTED or a flush in progress.
- Default (no event): pc_en=ifW=idex_W=exmem_W=memwb_W=1; all flushes 0.
- Priority in RUN, LU_STALL and FLUSH, highest first:
  1. halt_req -> all W=0, halted=1; next HALTED.
  2. mem_dreq & !dhit -> pc_en, ifW, idex_W, exmem_W=0; memwb_RST=1; next DMEM_WAIT.
  3. br_taken -> pc_en=1, ifRST=1, idex_RST=1, ifW=0; counter=FLUSH_CYCLES-1; next FLUSH (or RUN if FLUSH_CYCLES==1).
  4. Load-use, defined as ex_memread & ex_rd!=0 & (ex_rd==id_rsel1 | ex_rd==id_rsel2), and state!=LU_STALL -> pc_en=0, ifW=0, idex_RST=1; next LU_STALL.
  5. !ihit -> pc_en=0, ifW=0, ifRST=1 (bubble into ID); downstream stages advance.
- DMEM_WAIT:
  - Outputs as in rule 2 while dhit=0.
  - On dhit=1: default outputs this cycle; next RUN.
  - br_taken and load-use are ignored until exit.
- LU_STALL: lasts one cycle. Load-use detection is suppressed; other rules apply. Next RUN unless a higher-priority event occurs.
- FLUSH:
  - ifRST=idex_RST=1, pc_en=ihit; counter decrements.
  - At 0, next RUN.
  - A new br_taken reloads the counter.
  - A dmem wait pauses the counter; state returns to FLUSH after dhit.
- HALTED: sticky. pc_en and all W=0, halted=1, until RST.
- Register 0 never creates a hazard.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle with pc_en=0 and halted=0.
  - flush_cnt increments each cycle with ifRST=1 outside reset.
  - Both wrap at 2^32, clear on RST, freeze in HALTED.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg gains:
  - hz_state_t enum {RUN, LU_STALL, DMEM_WAIT, FLUSH, HALTED}
  - constant ZERO_REG = 5'd0
- One natural sub-module: hazard_detect, a purely combinational load-use compare (ex_memread, ex_rd, id_rsel1, id_rsel2 -> lu_hazard).
- The FSM stays in the top.

Test Plan:
- Reset: RST=1 for 2 cycles with all inputs 1 -> all W=0, ifRST/idex_RST/memwb_RST=1. First cycle after RST low with ihit=1 -> pc_en=ifW=1.
- Load-use: ex_memread=1, ex_rd=5, id_rsel2=5, ihit=1 -> one cycle pc_en=0, ifW=0, idex_RST=1, then default. Same with ex_rd=0 -> no stall.
- Dmem wait: mem_dreq=1, dhit=0 for 3 cycles -> exmem_W=0, memwb_RST=1 for 3 cycles. dhit=1 on cycle 4 -> all W=1. A br_taken during the wait has no effect.
- Flush with FLUSH_CYCLES=2: br_taken pulse -> ifRST=idex_RST=1 for exactly 2 cycles. A second br_taken in cycle 2 -> 2 more cycles.
- Priority: br_taken=1 and load-use in the same cycle -> flush only, pc_en=1.
- Halt: halt_req=1 -> halted=1 and all W=0 indefinitely despite ihit/br_taken. RST -> RUN. With HAZARD_PERF_EN, stall_cnt freezes while halted.
